// File: rtl/cascade_compare_fsm_if.sv
// Handshake bundle between a digit-comparator source and the cascade compare stage.
interface cascade_compare_fsm_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic             in_valid;
  logic             in_gt;
  logic             in_eq;
  logic             in_lt;
  logic             in_last;
  logic             busy;
  logic             done;
  logic             res_gt;
  logic             res_eq;
  logic             res_lt;
  logic             err;
  logic [CNT_W-1:0] digit_cnt;

  modport master (
    output start, in_valid, in_gt, in_eq, in_lt, in_last,
    input  busy, done, res_gt, res_eq, res_lt, err, digit_cnt
  );

  modport slave (
    input  start, in_valid, in_gt, in_eq, in_lt, in_last,
    output busy, done, res_gt, res_eq, res_lt, err, digit_cnt
  );
endinterface

// File: rtl/cascade_compare_fsm.sv
// Resolves the magnitude relation of two multi-digit words from MSB-first
// per-digit one-hot compare flags; reports a latched result with a done pulse.
module cascade_compare_fsm #(
  parameter int MAX_DIGITS = 8,
  parameter int CNT_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  cascade_compare_fsm_if.slave bus
);

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
  logic             dec_q, dec_d;
  logic             rgt_q, rgt_d;
  logic             rlt_q, rlt_d;
  logic             res_gt_q, res_gt_d;
  logic             res_eq_q, res_eq_d;
  logic             res_lt_q, res_lt_d;
  logic             flags_ok;
  logic             clr;
  logic             fin;

  assign flags_ok = ({bus.in_gt, bus.in_eq, bus.in_lt} == 3'b100) ||
                    ({bus.in_gt, bus.in_eq, bus.in_lt} == 3'b010) ||
                    ({bus.in_gt, bus.in_eq, bus.in_lt} == 3'b001);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    err_d    = err_q;
    dec_d    = dec_q;
    rgt_d    = rgt_q;
    rlt_d    = rlt_q;
    res_gt_d = res_gt_q;
    res_eq_d = res_eq_q;
    res_lt_d = res_lt_q;
    clr      = 1'b0;
    fin      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          clr     = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.start) begin
          clr = 1'b1;
        end else if (bus.in_valid) begin
          // A digit beyond capacity is an overflow: not counted, ends the word.
          if (cnt_q == CNT_W'(MAX_DIGITS)) begin
            err_d   = 1'b1;
            state_d = FIN;
            fin     = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
            if (!flags_ok) begin
              err_d = 1'b1;
            end else if (!dec_q && !bus.in_eq) begin
              dec_d = 1'b1;
              rgt_d = bus.in_gt;
              rlt_d = bus.in_lt;
            end
            if (bus.in_last) begin
              state_d = FIN;
              fin     = 1'b1;
            end
          end
        end
      end
      FIN: begin
        if (bus.start) begin
          clr     = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (clr) begin
      cnt_d    = '0;
      err_d    = 1'b0;
      dec_d    = 1'b0;
      rgt_d    = 1'b0;
      rlt_d    = 1'b0;
      res_gt_d = 1'b0;
      res_eq_d = 1'b0;
      res_lt_d = 1'b0;
    end

    // Results use the post-digit view so the final digit's effect is included.
    if (fin) begin
      res_gt_d = !err_d && dec_d && rgt_d;
      res_lt_d = !err_d && dec_d && rlt_d;
      res_eq_d = !err_d && !dec_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      err_q    <= 1'b0;
      dec_q    <= 1'b0;
      rgt_q    <= 1'b0;
      rlt_q    <= 1'b0;
      res_gt_q <= 1'b0;
      res_eq_q <= 1'b0;
      res_lt_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      err_q    <= err_d;
      dec_q    <= dec_d;
      rgt_q    <= rgt_d;
      rlt_q    <= rlt_d;
      res_gt_q <= res_gt_d;
      res_eq_q <= res_eq_d;
      res_lt_q <= res_lt_d;
    end
  end

  assign bus.busy      = (state_q == RUN);
  assign bus.done      = (state_q == FIN);
  assign bus.res_gt    = res_gt_q;
  assign bus.res_eq    = res_eq_q;
  assign bus.res_lt    = res_lt_q;
  assign bus.err       = err_q;
  assign bus.digit_cnt = cnt_q;

endmodule
